multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl.sv | 135 +++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle instruction sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB.
// Define MEM_TIMEOUT_EN to abort stalled memory handshakes and raise err.
`ifndef W_MEM_CMD
`define W_MEM_CMD 2
`endif
`ifndef MEM_NOP
`define MEM_NOP 2'd0
`endif
`ifndef MEM_READ
`define MEM_READ 2'd1
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2'd2
`endif
`ifndef W_PC_SRC
`define W_PC_SRC 2
`endif
`ifndef PC_SRC_NEXT
`define PC_SRC_NEXT 2'd0
`endif

module multi_cycle_ctrl (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic [`W_MEM_CMD-1:0] mem_cmd_in,
   input  logic                  reg_wen_in,
   input  logic [`W_PC_SRC-1:0]  pc_src_in,
   input  logic                  mem_rdy,
   output logic                  mem_req,
   output logic                  mem_addr_sel,
   output logic                  mem_wen,
   output logic                  ir_wen,
   output logic                  reg_wen,
   output logic                  pc_wen,
   output logic [`W_PC_SRC-1:0]  pc_src,
   output logic                  retired,
   output logic [2:0]            state,
   output logic                  err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5
   } state_e;

   state_e state_q, state_d;
   logic   retire;
   logic   tmo;

   always_comb begin
      state_d      = state_q;
      mem_req      = 1'b0;
      mem_addr_sel = 1'b0;
      mem_wen      = 1'b0;
      ir_wen       = 1'b0;
      reg_wen      = 1'b0;
      retire       = 1'b0;
      case (state_q)
         IDLE: begin
            if (run) state_d = FETCH;
         end
         FETCH: begin
            mem_req = 1'b1;
            if (mem_rdy) begin
               ir_wen  = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: state_d = EXEC;
         EXEC: begin
            if (mem_cmd_in != `MEM_NOP) state_d = MEM;
            else if (reg_wen_in)        state_d = WB;
            else                        retire  = 1'b1;
         end
         MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_wen      = (mem_cmd_in == `MEM_WRITE);
            if (mem_rdy) begin
               if (mem_cmd_in == `MEM_READ) state_d = WB;
               else                         retire  = 1'b1;
            end
         end
         WB: begin
            reg_wen = reg_wen_in;
            retire  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (retire) state_d = run ? FETCH : IDLE;
      // a timed-out transfer refetches the same PC
      if (tmo) state_d = FETCH;
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   assign pc_wen  = retire;
   assign retired = retire;
   assign pc_src  = retire ? pc_src_in : `PC_SRC_NEXT;
   assign state   = state_q;

`ifdef MEM_TIMEOUT_EN
   logic [3:0] cnt_q;
   logic       err_q;

   assign tmo = mem_req && !mem_rdy && (cnt_q == 4'hf);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= 4'd0;
         err_q <= 1'b0;
      end else begin
         if (tmo) err_q <= 1'b1;
         if (tmo || state_d != state_q)
            cnt_q <= 4'd0;
         else if (mem_req && !mem_rdy)
            cnt_q <= cnt_q + 4'd1;
      end
   end

   assign err = err_q;
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: directed per-cycle vectors.
// Build with MEM_TIMEOUT_EN to exercise the handshake timeout.
`ifndef W_MEM_CMD
`define W_MEM_CMD 2
`endif
`ifndef W_PC_SRC
`define W_PC_SRC 2
`endif

module tb_multi_cycle_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       run = 1'b0;
   logic [1:0] mem_cmd_in = 2'd0;
   logic       reg_wen_in = 1'b0;
   logic [1:0] pc_src_in = 2'd0;
   logic       mem_rdy = 1'b0;
   logic       mem_req, mem_addr_sel, mem_wen, ir_wen;
   logic       reg_wen, pc_wen, retired, err;
   logic [1:0] pc_src;
   logic [2:0] state;

   multi_cycle_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .run          (run),
      .mem_cmd_in   (mem_cmd_in),
      .reg_wen_in   (reg_wen_in),
      .pc_src_in    (pc_src_in),
      .mem_rdy      (mem_rdy),
      .mem_req      (mem_req),
      .mem_addr_sel (mem_addr_sel),
      .mem_wen      (mem_wen),
      .ir_wen       (ir_wen),
      .reg_wen      (reg_wen),
      .pc_wen       (pc_wen),
      .pc_src       (pc_src),
      .retired      (retired),
      .state        (state),
      .err          (err)
   );

   always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif

   // strobe order: req, addr_sel, wen, ir_wen, reg_wen, pc_wen, retired
   localparam logic [6:0] Z   = 7'b0000000;
   localparam logic [6:0] FOK = 7'b1001000;
   localparam logic [6:0] FW  = 7'b1000000;
   localparam logic [6:0] MRD = 7'b1100000;
   localparam logic [6:0] MWR = 7'b1110011;
   localparam logic [6:0] WBW = 7'b0000111;
   localparam logic [6:0] RET = 7'b0000011;

   typedef struct {
      int          id;
      logic [12:0] v;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   task automatic step(input logic r, input logic rn,
                       input logic [1:0] cmd, input logic rw,
                       input logic [1:0] pcs, input logic rdy,
                       input logic [2:0] es, input logic [6:0] eo,
                       input logic [1:0] epc, input logic eerr);
      exp_t e;
      @(posedge clk);
      #1;
      rst        = r;
      run        = rn;
      mem_cmd_in = cmd;
      reg_wen_in = rw;
      pc_src_in  = pcs;
      mem_rdy    = rdy;
      e.id = cyc;
      e.v  = {es, eo, epc, eerr};
      q.push_back(e);
      cyc++;
   endtask

   always @(negedge clk) begin
      exp_t        e;
      logic [12:0] act;
      if (q.size() > 0) begin
         e   = q.pop_front();
         act = {state, mem_req, mem_addr_sel, mem_wen, ir_wen,
                reg_wen, pc_wen, retired, pc_src, err};
         checks++;
         if (act !== e.v) begin
            failures++;
            $display("FAIL cyc%0d outputs got %b want %b", e.id, act, e.v);
         end
      end
   end

   initial begin
      // reset holds IDLE even with run and mem_rdy high
      step(0,1,0,0,0,1, 0,Z,0,0);
      step(0,1,0,0,0,1, 0,Z,0,0);
      // ALU op with write
      step(1,1,0,1,1,1, 0,Z,0,0);
      step(1,1,0,1,1,1, 1,FOK,0,0);
      step(1,1,0,1,1,1, 2,Z,0,0);
      step(1,1,0,1,1,1, 3,Z,0,0);
      step(1,1,0,1,1,1, 5,WBW,1,0);
      // load with three MEM wait cycles
      step(1,1,1,1,0,1, 1,FOK,0,0);
      step(1,1,1,1,0,1, 2,Z,0,0);
      step(1,1,1,1,0,1, 3,Z,0,0);
      step(1,1,1,1,0,0, 4,MRD,0,0);
      step(1,1,1,1,0,0, 4,MRD,0,0);
      step(1,1,1,1,0,0, 4,MRD,0,0);
      step(1,1,1,1,0,1, 4,MRD,0,0);
      step(1,1,1,1,0,1, 5,WBW,0,0);
      // store, one FETCH wait cycle
      step(1,1,2,0,3,0, 1,FW,0,0);
      step(1,1,2,0,3,1, 1,FOK,0,0);
      step(1,1,2,0,3,1, 2,Z,0,0);
      step(1,1,2,0,3,1, 3,Z,0,0);
      step(1,1,2,0,3,1, 4,MWR,3,0);
      // branch, run dropped in EXEC
      step(1,1,0,0,2,1, 1,FOK,0,0);
      step(1,1,0,0,2,1, 2,Z,0,0);
      step(1,0,0,0,2,1, 3,RET,2,0);
      step(1,0,0,0,2,1, 0,Z,0,0);
      step(1,0,0,0,2,1, 0,Z,0,0);
      // run dropped mid-instruction still completes
      step(1,1,0,1,1,1, 0,Z,0,0);
      step(1,0,0,1,1,1, 1,FOK,0,0);
      step(1,0,0,1,1,1, 2,Z,0,0);
      step(1,0,0,1,1,1, 3,Z,0,0);
      step(1,0,0,1,1,1, 5,WBW,1,0);
      step(1,0,0,1,1,1, 0,Z,0,0);
      // reset during outstanding MEM request
      step(1,1,1,1,0,1, 0,Z,0,0);
      step(1,1,1,1,0,1, 1,FOK,0,0);
      step(1,1,1,1,0,1, 2,Z,0,0);
      step(1,1,1,1,0,1, 3,Z,0,0);
      step(1,1,1,1,0,0, 4,MRD,0,0);
      step(0,1,1,1,0,0, 4,MRD,0,0);
      step(1,0,1,1,0,1, 0,Z,0,0);
      // long FETCH stall
      step(1,1,0,0,0,0, 0,Z,0,0);
      for (int i = 0; i < 120; i++)
         step(1,1,0,0,0,0, 1,FW,0, (i >= 16) && TMO);
      step(1,1,0,0,0,1, 1,FOK,0,TMO);
      step(0,1,0,0,0,1, 2,Z,0,TMO);
      step(1,0,0,0,0,1, 0,Z,0,0);
      repeat (2) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain pending got %0d want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
